// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - phase sequencer and instruction-fetch stage for the 16-bit multi-cycle CPU
//
// Owns the program counter and the instruction register, and drives the
// one-hot phase bus. One instruction is fetched per PH0..PH3 round over a
// request/acknowledge memory port. The next PC is committed in PH3.
//
// Ports:
//   CLK, RST     clock and synchronous active-high reset
//   imem_req     registered fetch request (PH0 only)
//   imem_addr    fetch address, wire copy of pc
//   imem_rdata   instruction word, taken when imem_req && imem_ack
//   imem_ack     memory acknowledge, ignored while imem_req is 0
//   q            ALU result, valid in PH3
//   pc_ld        load pc from q in PH3
//   halt         stop after the current PH3
//   pc, ir       program counter, instruction register
//   ph           one-hot phase (0000 when halted)
//   halted       sequencer stopped
//   fetch_err    sticky fetch-timeout flag
//   icount       retired-instruction counter
module fetch_seq #(
  parameter logic [15:0] RESET_PC = 16'h0000,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_ack,
  input  logic [15:0] q,
  input  logic        pc_ld,
  input  logic        halt,
  output logic [15:0] pc,
  output logic [15:0] ir,
  output logic [3:0]  ph,
  output logic        halted,
  output logic        fetch_err,
  output logic [15:0] icount
);

  typedef enum logic [2:0] {
    S_PH0  = 3'd0,
    S_PH1  = 3'd1,
    S_PH2  = 3'd2,
    S_PH3  = 3'd3,
    S_HALT = 3'd4
  } state_e;

  localparam logic [16:0] TIMEOUT_C = 17'(TIMEOUT);

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        err_q, err_d;
  logic [15:0] icount_q, icount_d;
  logic [15:0] tcnt_q, tcnt_d;

  logic fetch_ok;
  logic fetch_wait;
  logic tmo_hit;

  assign fetch_ok   = (state_q == S_PH0) && req_q && imem_ack;
  assign fetch_wait = (state_q == S_PH0) && req_q && !imem_ack;
  // Trip on the edge where the wait counter would reach TIMEOUT, i.e. after
  // TIMEOUT consecutive unacknowledged request cycles.
  assign tmo_hit    = fetch_wait && (({1'b0, tcnt_q} + 17'd1) == TIMEOUT_C);

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= S_PH0;
      req_q    <= 1'b0;
      pc_q     <= RESET_PC;
      ir_q     <= 16'h0000;
      err_q    <= 1'b0;
      icount_q <= 16'h0000;
      tcnt_q   <= 16'h0000;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      pc_q     <= pc_d;
      ir_q     <= ir_d;
      err_q    <= err_d;
      icount_q <= icount_d;
      tcnt_q   <= tcnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_PH0: begin
        if (fetch_ok)     state_d = S_PH1;
        else if (tmo_hit) state_d = S_HALT;
      end
      S_PH1:   state_d = S_PH2;
      S_PH2:   state_d = S_PH3;
      S_PH3:   state_d = halt ? S_HALT : S_PH0;
      default: state_d = S_HALT;
    endcase
  end

  // Datapath next values and output decode
  always_comb begin
    req_d    = req_q;
    pc_d     = pc_q;
    ir_d     = ir_q;
    err_d    = err_q;
    icount_d = icount_q;
    tcnt_d   = tcnt_q;
    ph       = 4'b0000;
    case (state_q)
      S_PH0: begin
        ph = 4'b0001;
        if (!req_q) begin
          req_d = 1'b1;
        end else if (imem_ack) begin
          ir_d   = imem_rdata;
          pc_d   = pc_q + 16'd1;
          req_d  = 1'b0;
          tcnt_d = 16'h0000;
        end else begin
          tcnt_d = tcnt_q + 16'd1;
          if (tmo_hit) begin
            err_d = 1'b1;
            req_d = 1'b0;
          end
        end
      end
      S_PH1: ph = 4'b0010;
      S_PH2: ph = 4'b0100;
      S_PH3: begin
        ph       = 4'b1000;
        pc_d     = pc_ld ? q : pc_q;
        icount_d = icount_q + 16'd1;
        // Raising the request on the PH3 edge avoids an idle cycle in PH0.
        req_d    = !halt;
      end
      default: ph = 4'b0000;
    endcase
  end

  assign imem_req  = req_q;
  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign ir        = ir_q;
  assign halted    = (state_q == S_HALT);
  assign fetch_err = err_q;
  assign icount    = icount_q;

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - directed self-checking bench for fetch_seq
module tb_fetch_seq;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        rst_a, rst_b, ack_a, ack_b, pc_ld, halt;
  logic [15:0] rdata, q;

  logic        req_a, halted_a, err_a;
  logic [15:0] addr_a, pc_a, ir_a, icnt_a;
  logic [3:0]  ph_a;
  logic        req_b, halted_b, err_b;
  logic [15:0] addr_b, pc_b, ir_b, icnt_b;
  logic [3:0]  ph_b;

  int n_vec = 0;
  int n_err = 0;

  fetch_seq u_a (
    .CLK(CLK), .RST(rst_a), .imem_req(req_a), .imem_addr(addr_a),
    .imem_rdata(rdata), .imem_ack(ack_a), .q(q), .pc_ld(pc_ld), .halt(halt),
    .pc(pc_a), .ir(ir_a), .ph(ph_a), .halted(halted_a), .fetch_err(err_a),
    .icount(icnt_a)
  );

  fetch_seq #(.RESET_PC(16'hFFFF), .TIMEOUT(4)) u_b (
    .CLK(CLK), .RST(rst_b), .imem_req(req_b), .imem_addr(addr_b),
    .imem_rdata(rdata), .imem_ack(ack_b), .q(q), .pc_ld(pc_ld), .halt(halt),
    .pc(pc_b), .ir(ir_b), .ph(ph_b), .halted(halted_b), .fetch_err(err_b),
    .icount(icnt_b)
  );

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic test_reset();
    rst_a = 1'b1;
    tick();
    n_vec++; if (ph_a !== 4'b0001) begin n_err++; $display("FAIL reset_ph: got %b want 0001", ph_a); end
    n_vec++; if (pc_a !== 16'h0000) begin n_err++; $display("FAIL reset_pc: got %h want 0000", pc_a); end
    n_vec++; if (ir_a !== 16'h0000) begin n_err++; $display("FAIL reset_ir: got %h want 0000", ir_a); end
    n_vec++; if (req_a !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", req_a); end
    n_vec++; if (halted_a !== 1'b0) begin n_err++; $display("FAIL reset_halted: got %b want 0", halted_a); end
    n_vec++; if (err_a !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", err_a); end
    n_vec++; if (icnt_a !== 16'h0000) begin n_err++; $display("FAIL reset_icount: got %h want 0000", icnt_a); end
  endtask

  task automatic test_zero_wait();
    logic [3:0] exp_ph [5];
    exp_ph = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    rst_a = 1'b0;
    ack_a = 1'b1;
    rdata = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      tick();
      n_vec++; if (ph_a !== exp_ph[i]) begin n_err++; $display("FAIL zw_ph[%0d]: got %b want %b", i, ph_a, exp_ph[i]); end
      if (i == 0) begin
        n_vec++; if (req_a !== 1'b1) begin n_err++; $display("FAIL zw_req_rise: got %b want 1", req_a); end
      end
      if (i == 1) begin
        n_vec++; if (ir_a !== 16'h1234) begin n_err++; $display("FAIL zw_ir: got %h want 1234", ir_a); end
        n_vec++; if (pc_a !== 16'h0001) begin n_err++; $display("FAIL zw_pc: got %h want 0001", pc_a); end
        n_vec++; if (req_a !== 1'b0) begin n_err++; $display("FAIL zw_req_fall: got %b want 0", req_a); end
        rdata = 16'hFFFF;
      end
      if (i == 3) begin
        n_vec++; if (ir_a !== 16'h1234) begin n_err++; $display("FAIL zw_ir_stable: got %h want 1234", ir_a); end
      end
      if (i == 4) begin
        n_vec++; if (icnt_a !== 16'h0001) begin n_err++; $display("FAIL zw_icount: got %h want 0001", icnt_a); end
        n_vec++; if (req_a !== 1'b1) begin n_err++; $display("FAIL zw_req_noidle: got %b want 1", req_a); end
        n_vec++; if (addr_a !== 16'h0001) begin n_err++; $display("FAIL zw_addr: got %h want 0001", addr_a); end
        ack_a = 1'b0;
      end
    end
  endtask

  task automatic test_wait_states();
    ack_a = 1'b0;
    rdata = 16'h5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (ph_a !== 4'b0001) begin n_err++; $display("FAIL ws_ph[%0d]: got %b want 0001", i, ph_a); end
      n_vec++; if (req_a !== 1'b1) begin n_err++; $display("FAIL ws_req[%0d]: got %b want 1", i, req_a); end
      n_vec++; if (ir_a !== 16'h1234) begin n_err++; $display("FAIL ws_ir_hold[%0d]: got %h want 1234", i, ir_a); end
    end
    ack_a = 1'b1;
    tick();
    n_vec++; if (ph_a !== 4'b0010) begin n_err++; $display("FAIL ws_ph_ack: got %b want 0010", ph_a); end
    n_vec++; if (ir_a !== 16'h5678) begin n_err++; $display("FAIL ws_ir: got %h want 5678", ir_a); end
    n_vec++; if (req_a !== 1'b0) begin n_err++; $display("FAIL ws_req_fall: got %b want 0", req_a); end
    n_vec++; if (pc_a !== 16'h0002) begin n_err++; $display("FAIL ws_pc: got %h want 0002", pc_a); end
    ack_a = 1'b0;
  endtask

  task automatic test_branch();
    pc_ld = 1'b1;
    q     = 16'h9999;
    tick();
    n_vec++; if (pc_a !== 16'h0002) begin n_err++; $display("FAIL br_ignore_ph1: got %h want 0002", pc_a); end
    tick();
    n_vec++; if (ph_a !== 4'b1000) begin n_err++; $display("FAIL br_ph3: got %b want 1000", ph_a); end
    n_vec++; if (pc_a !== 16'h0002) begin n_err++; $display("FAIL br_ignore_ph2: got %h want 0002", pc_a); end
    q = 16'h0040;
    tick();
    n_vec++; if (addr_a !== 16'h0040) begin n_err++; $display("FAIL br_addr: got %h want 0040", addr_a); end
    n_vec++; if (icnt_a !== 16'h0002) begin n_err++; $display("FAIL br_icount: got %h want 0002", icnt_a); end
    n_vec++; if (req_a !== 1'b1) begin n_err++; $display("FAIL br_req: got %b want 1", req_a); end
    pc_ld = 1'b0;
    ack_a = 1'b1;
    rdata = 16'h1111;
    tick();
    n_vec++; if (pc_a !== 16'h0041) begin n_err++; $display("FAIL br_pc_inc: got %h want 0041", pc_a); end
    n_vec++; if (ir_a !== 16'h1111) begin n_err++; $display("FAIL br_ir: got %h want 1111", ir_a); end
  endtask

  task automatic test_halt();
    tick();
    tick();
    pc_ld = 1'b1;
    q     = 16'h0010;
    halt  = 1'b1;
    tick();
    n_vec++; if (pc_a !== 16'h0010) begin n_err++; $display("FAIL hl_pc: got %h want 0010", pc_a); end
    n_vec++; if (ph_a !== 4'b0000) begin n_err++; $display("FAIL hl_ph: got %b want 0000", ph_a); end
    n_vec++; if (halted_a !== 1'b1) begin n_err++; $display("FAIL hl_halted: got %b want 1", halted_a); end
    n_vec++; if (req_a !== 1'b0) begin n_err++; $display("FAIL hl_req: got %b want 0", req_a); end
    n_vec++; if (icnt_a !== 16'h0003) begin n_err++; $display("FAIL hl_icount: got %h want 0003", icnt_a); end
    pc_ld = 1'b0;
    halt  = 1'b0;
    ack_a = 1'b1;
    rdata = 16'h2222;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (ph_a !== 4'b0000) begin n_err++; $display("FAIL hl_stay_ph[%0d]: got %b want 0000", i, ph_a); end
      n_vec++; if (ir_a !== 16'h1111) begin n_err++; $display("FAIL hl_stay_ir[%0d]: got %h want 1111", i, ir_a); end
      n_vec++; if (pc_a !== 16'h0010) begin n_err++; $display("FAIL hl_stay_pc[%0d]: got %h want 0010", i, pc_a); end
    end
    rst_a = 1'b1;
    ack_a = 1'b0;
    tick();
    n_vec++; if (ph_a !== 4'b0001) begin n_err++; $display("FAIL hl_rst_ph: got %b want 0001", ph_a); end
    n_vec++; if (halted_a !== 1'b0) begin n_err++; $display("FAIL hl_rst_halted: got %b want 0", halted_a); end
    n_vec++; if (icnt_a !== 16'h0000) begin n_err++; $display("FAIL hl_rst_icount: got %h want 0000", icnt_a); end
  endtask

  task automatic test_reset_midfetch();
    rst_a = 1'b0;
    ack_a = 1'b0;
    tick();
    n_vec++; if (req_a !== 1'b1) begin n_err++; $display("FAIL mf_req: got %b want 1", req_a); end
    rst_a = 1'b1;
    ack_a = 1'b1;
    rdata = 16'hBEEF;
    tick();
    n_vec++; if (ir_a !== 16'h0000) begin n_err++; $display("FAIL mf_ir: got %h want 0000", ir_a); end
    n_vec++; if (pc_a !== 16'h0000) begin n_err++; $display("FAIL mf_pc: got %h want 0000", pc_a); end
    n_vec++; if (req_a !== 1'b0) begin n_err++; $display("FAIL mf_req_clr: got %b want 0", req_a); end
    n_vec++; if (ph_a !== 4'b0001) begin n_err++; $display("FAIL mf_ph: got %b want 0001", ph_a); end
    ack_a = 1'b0;
  endtask

  task automatic test_pc_wrap();
    pc_ld = 1'b0;
    halt  = 1'b0;
    ack_b = 1'b0;
    rst_b = 1'b1;
    tick();
    n_vec++; if (pc_b !== 16'hFFFF) begin n_err++; $display("FAIL wr_reset_pc: got %h want ffff", pc_b); end
    rst_b = 1'b0;
    ack_b = 1'b1;
    rdata = 16'h4321;
    tick();
    tick();
    n_vec++; if (pc_b !== 16'h0000) begin n_err++; $display("FAIL wr_pc: got %h want 0000", pc_b); end
    n_vec++; if (ir_b !== 16'h4321) begin n_err++; $display("FAIL wr_ir: got %h want 4321", ir_b); end
    ack_b = 1'b0;
    tick();
    tick();
    tick();
    n_vec++; if (addr_b !== 16'h0000) begin n_err++; $display("FAIL wr_addr: got %h want 0000", addr_b); end
    n_vec++; if (req_b !== 1'b1) begin n_err++; $display("FAIL wr_req: got %b want 1", req_b); end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++; if (err_b !== 1'b0) begin n_err++; $display("FAIL to_early_err[%0d]: got %b want 0", i, err_b); end
      n_vec++; if (req_b !== 1'b1) begin n_err++; $display("FAIL to_early_req[%0d]: got %b want 1", i, req_b); end
    end
    tick();
    n_vec++; if (err_b !== 1'b1) begin n_err++; $display("FAIL to_err: got %b want 1", err_b); end
    n_vec++; if (halted_b !== 1'b1) begin n_err++; $display("FAIL to_halted: got %b want 1", halted_b); end
    n_vec++; if (req_b !== 1'b0) begin n_err++; $display("FAIL to_req: got %b want 0", req_b); end
    n_vec++; if (ph_b !== 4'b0000) begin n_err++; $display("FAIL to_ph: got %b want 0000", ph_b); end
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ack_a = 1'b0;
    ack_b = 1'b0;
    pc_ld = 1'b0;
    halt  = 1'b0;
    rdata = 16'h0000;
    q     = 16'h0000;
    test_reset();
    test_zero_wait();
    test_wait_states();
    test_branch();
    test_halt();
    test_reset_midfetch();
    test_pc_wrap();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Phase sequencer and instruction-fetch stage for the 16-bit multi-cycle CPU. It owns the program counter and the instruction register and drives the one-hot phase bus consumed by the ALU and the other execute/writeback logic. It fetches one instruction word per cycle of phases PH0..PH3 over a simple request/acknowledge memory port. It commits the next PC in PH3 from either the incremented PC or the ALU result.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- TIMEOUT, 255, maximum cycles `imem_req` may stay high without `imem_ack` before the fetch error trips; range 1..65535.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  reset; one clock, synchronous, active-high.
- imem_req  out  1  fetch request, registered.
- imem_addr  out  16  fetch address; always equals `pc`.
- imem_rdata  in  16  instruction word; sampled only when `imem_req` and `imem_ack` are both 1.
- imem_ack  in  1  memory acknowledge; ignored while `imem_req` is 0.
- q  in  16  ALU result; registered by the ALU at the end of PH2, so valid throughout PH3.
- pc_ld  in  1  from decode: load `pc` from `q` in PH3 (branch instructions).
- halt  in  1  from decode: stop after the current PH3.
- pc  out  16  program counter.
- ir  out  16  instruction register.
- ph  out  4  phase, one-hot: PH0=4'b0001 (fetch), PH1=4'b0010 (decode/read), PH2=4'b0100 (execute), PH3=4'b1000 (writeback); 4'b0000 when halted.
- halted  out  1  sequencer stopped.
- fetch_err  out  1  sticky; set on fetch timeout.
- icount  out  16  retired-instruction counter.

## Operation
- Reset values:
  - ph=PH0, pc=RESET_PC, ir=16'h0000, imem_req=0
  - halted=0, fetch_err=0, icount=0, timeout counter=0
- States map one-to-one to `ph`: PH0, PH1, PH2, PH3, HALT.
- PH0, request not yet raised (`imem_req`=0): set `imem_req`=1 at the next edge.
- PH0, `imem_req`=1 and `imem_ack`=1 at the same edge:
  - ir<=imem_rdata, pc<=pc+1, imem_req<=0
  - ph<=PH1, timeout counter<=0
- PH0, `imem_req`=1 and `imem_ack`=0: increment the timeout counter.
  - When the counter reaches TIMEOUT: fetch_err<=1, halted<=1, imem_req<=0, ph<=HALT.
- The PC is incremented at fetch. The ALU therefore sees pc = fetched address + 1 in PH1..PH3, and branch targets are relative to that value.
  - A not-taken conditional branch returns q=pc, so loading it leaves the PC unchanged.
- PH1 -> PH2 -> PH3 unconditionally, one cycle each.
- PH3 edge:
  - pc <= pc_ld ? q : pc (no further increment)
  - icount <= icount+1, wrapping at 16'hFFFF -> 0
  - If halt=1: ph<=HALT, halted<=1, imem_req stays 0.
  - Otherwise: ph<=PH0 and imem_req<=1 in the same edge, so no idle cycle.
- `pc_ld` and `halt` are sampled only in PH3; their values in other phases are ignored.
- If `pc_ld` and `halt` are both 1 in PH3, the PC load takes effect, then the block halts.
- PC arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000.
- HALT is left only via RST. In HALT, pc, ir and icount hold their values and `ack` is ignored.
- RST asserted in any state, including mid-fetch with `imem_req`=1: every register takes its reset value at that edge. A late `ack` arriving while RST is high is discarded.

## Timing
- All outputs are registered. `imem_addr` is a wire copy of `pc`.
- First fetch after reset release:
  - cycle 0: `imem_req` rises at the end of cycle 0.
  - cycle 1: earliest cycle an ack can be accepted.
- Zero-wait memory (ack in the same cycle as req): 4 cycles per instruction, one each in PH0, PH1, PH2, PH3.
- Each wait cycle on ack extends PH0 by one cycle.
- `ir` changes only on the PH0->PH1 edge and is stable for PH1..PH3.
- `pc` changes only on the PH0->PH1 edge (+1) and the PH3 edge (load).
- Timeout trips when the counter reaches TIMEOUT, i.e. after TIMEOUT consecutive cycles with req=1 and ack=0.

## Test plan
- Reset, then zero-wait memory returning 16'h1234 at address 0, pc_ld=0, halt=0:
  - ph sequence after reset: 0001, 0001, 0010, 0100, 1000, 0001, ...
  - ir=16'h1234 from PH1; pc=1 from PH1; icount=1 after the first PH3.
- Memory acks after 3 wait cycles: PH0 lasts 4 cycles with req high; ir is captured only on the ack edge; req falls on that same edge.
- RESET_PC=16'hFFFF with pc_ld=0: pc=16'h0000 after fetch, and the next imem_addr=16'h0000.
- In PH3 drive pc_ld=1, q=16'h0040: the next PH0 has imem_addr=16'h0040, and the following PH1 has pc=16'h0041.
- In PH3 drive pc_ld=1, q=16'h0010 and halt=1:
  - pc=16'h0010, ph=0000, halted=1, req=0.
  - Further acks have no effect; RST restores ph=0001.
- TIMEOUT=4, ack held at 0: fetch_err=1, halted=1 and req=0 after 4 cycles with req high.
- Separately, assert RST while req=1 with ack arriving in the same cycle: ir stays 0 and pc=RESET_PC.
